dot_fp6: RTL and testbench



---
 rtl/dot_fp6_pkg.sv | 41 ++++
 rtl/dot_fp6_fp_to_fixed.sv | 26 ++
 rtl/dot_fp6.sv | 77 +++++++
 tb/tb_dot_fp6.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_fp6_pkg.sv
// Shared width helpers, element-field struct and the element-to-fixed conversion
// used by the dot_fp6 exact dot-product engine.
package dot_fp6_pkg;

  localparam int max_exp_width = 8;
  localparam int max_man_width = 16;

  function automatic int fi_width_f(input int man_width);
    return man_width + 2;
  endfunction

  function automatic int fix_width_f(input int exp_width, input int man_width);
    return (1 << exp_width) + fi_width_f(man_width);
  endfunction

  function automatic int prd_width_f(input int exp_width, input int man_width);
    return 2 * fix_width_f(exp_width, man_width);
  endfunction

  function automatic int out_width_f(input int exp_width, input int man_width, input int k);
    return prd_width_f(exp_width, man_width) + $clog2(k);
  endfunction

  // Fields are sized for the widest supported format; narrower formats zero-extend.
  typedef struct packed {
    logic                     sign;
    logic [max_exp_width-1:0] exp;
    logic [max_man_width-1:0] man;
  } fp_elem_t;

  function automatic logic signed [63:0] fix_value(input fp_elem_t e, input int man_width);
    logic [63:0] mag;
    if (e.exp == '0) begin
      mag = 64'(e.man);
    end else begin
      mag = (64'(e.man) | (64'd1 << man_width)) << (e.exp - 1'b1);
    end
    return e.sign ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/dot_fp6_fp_to_fixed.sv
// Converts one {sign, exp, man} element into its exact signed fixed-point value,
// where one unit is the minimum subnormal.
module fp_to_fixed
  import dot_fp6_pkg::*;
#(
  parameter  int exp_width = 2,
  parameter  int man_width = 3,
  localparam int bit_width = 1 + exp_width + man_width,
  localparam int fix_width = fix_width_f(exp_width, man_width)
) (
  input  logic        [bit_width-1:0] elem,
  output logic signed [fix_width-1:0] fix
);

  fp_elem_t fields;

  always_comb begin
    fields      = '0;
    fields.sign = elem[bit_width-1];
    fields.exp  = max_exp_width'(elem[bit_width-2 -: exp_width]);
    fields.man  = max_man_width'(elem[man_width-1:0]);
  end

  assign fix = fix_width'(fix_value(fields, man_width));

endmodule

// File: rtl/dot_fp6.sv
// Exact, fully pipelined dot product of k small-float element pairs.
// Optional DOT_FP6_PIPE_EN adds a register stage between products and adder tree.
module dot_fp6
  import dot_fp6_pkg::*;
#(
  parameter  int exp_width = 2,
  parameter  int man_width = 3,
  parameter  int k         = 32,
  localparam int bit_width = 1 + exp_width + man_width,
  localparam int fi_width  = fi_width_f(man_width),
  localparam int prd_width = prd_width_f(exp_width, man_width),
  localparam int out_width = out_width_f(exp_width, man_width, k)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic signed [bit_width-1:0] i_vec_a [k],
  input  logic signed [bit_width-1:0] i_vec_b [k],
  output logic signed [out_width-1:0] o_dp
);

  localparam int fix_width = (1 << exp_width) + fi_width;
  localparam int depth     = $clog2(k);

  logic signed [fix_width-1:0] fix_a   [k];
  logic signed [fix_width-1:0] fix_b   [k];
  logic signed [prd_width-1:0] prd     [k];
  logic signed [prd_width-1:0] tree_in [k];

  for (genvar j = 0; j < k; j++) begin : g_elem
    fp_to_fixed #(.exp_width(exp_width), .man_width(man_width)) u_fix_a (
      .elem(i_vec_a[j]),
      .fix (fix_a[j])
    );
    fp_to_fixed #(.exp_width(exp_width), .man_width(man_width)) u_fix_b (
      .elem(i_vec_b[j]),
      .fix (fix_b[j])
    );
    assign prd[j] = prd_width'(fix_a[j]) * prd_width'(fix_b[j]);
  end

`ifdef DOT_FP6_PIPE_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < k; j++) tree_in[j] <= '0;
    end else begin
      for (int j = 0; j < k; j++) tree_in[j] <= prd[j];
    end
  end
`else
  assign tree_in = prd;
`endif

  // Level l holds ceil(k / 2^l) partial sums; an unpaired last node passes straight up.
  for (genvar l = 0; l <= depth; l++) begin : g_lvl
    localparam int n      = (k + (1 << l) - 1) >> l;
    localparam int n_prev = (l == 0) ? k : ((k + (1 << (l - 1)) - 1) >> (l - 1));
    logic signed [out_width-1:0] node [n];
    for (genvar i = 0; i < n; i++) begin : g_node
      if (l == 0) begin : g_leaf
        assign node[i] = out_width'(tree_in[i]);
      end else if (2 * i + 1 < n_prev) begin : g_add
        assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end else begin : g_pass
        assign node[i] = g_lvl[l-1].node[2*i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dp <= '0;
    end else begin
      o_dp <= g_lvl[depth].node[0];
    end
  end

endmodule

// File: tb/tb_dot_fp6.sv
// Self-checking bench for dot_fp6 (E2M3, k=32); checks against a real-number model.
// Honours DOT_FP6_PIPE_EN for the expected latency.
module tb_dot_fp6;

  localparam int EXP_W = 2;
  localparam int MAN_W = 3;
  localparam int K     = 32;
  localparam int BW    = 1 + EXP_W + MAN_W;
  localparam int OW    = 23;
  localparam int N_RND = 65536;
`ifdef DOT_FP6_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [BW-1:0] vec_a [K];
  logic signed [BW-1:0] vec_b [K];
  logic signed [OW-1:0] dp;

  int n_checks = 0;
  int n_fails  = 0;

  dot_fp6 dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_vec_a(vec_a),
    .i_vec_b(vec_b),
    .o_dp   (dp)
  );

  always #5 clk = ~clk;

  // Real value of one element: normal 2^exp * 1.man, subnormal 2 * 0.man.
  function automatic real elem_val(input logic [BW-1:0] e);
    int  ex;
    int  m;
    real v;
    ex = int'(e[BW-2 -: EXP_W]);
    m  = int'(e[MAN_W-1:0]);
    if (ex == 0) v = 2.0 * real'(m) / real'(1 << MAN_W);
    else         v = real'(1 << ex) * (1.0 + real'(m) / real'(1 << MAN_W));
    return e[BW-1] ? -v : v;
  endfunction

  function automatic logic signed [OW-1:0] ref_dp();
    real s;
    real scale;
    s = 0.0;
    for (int j = 0; j < K; j++) s += elem_val(vec_a[j]) * elem_val(vec_b[j]);
    scale = real'(1 << (2 * (MAN_W - 1)));
    return OW'(longint'(s * scale));
  endfunction

  task automatic fill(input logic [BW-1:0] a, input logic [BW-1:0] b);
    for (int j = 0; j < K; j++) begin
      vec_a[j] = a;
      vec_b[j] = b;
    end
  endtask

  task automatic rand_vecs();
    for (int j = 0; j < K; j++) begin
      vec_a[j] = BW'($urandom_range(0, (1 << BW) - 1));
      vec_b[j] = BW'($urandom_range(0, (1 << BW) - 1));
    end
  endtask

  task automatic settle();
    repeat (LAT) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic signed [OW-1:0] e;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_vecs();
      @(negedge clk);
      n_checks++;
      if (dp !== '0) begin
        n_fails++;
        $display("FAIL reset_hold: got %0d expected 0", dp);
      end
    end
    rst_n = 1'b1;
    fill(6'b0_01_000, 6'b0_11_111);
    vec_a[K-1] = 6'b1_10_011;
    vec_b[K-1] = 6'b0_00_101;
    e = ref_dp();
    @(posedge clk);
    @(negedge clk);
`ifdef DOT_FP6_PIPE_EN
    n_checks++;
    if (dp !== '0) begin
      n_fails++;
      $display("FAIL reset_first_edge: got %0d expected 0", dp);
    end
    @(posedge clk);
    @(negedge clk);
`endif
    n_checks++;
    if (dp !== e) begin
      n_fails++;
      $display("FAIL reset_release: got %0d expected %0d", dp, e);
    end
  endtask

  task automatic test_min_subnormal();
    fill(6'b0_00_001, 6'b0_00_001);
    settle();
    n_checks++;
    if (dp !== 23'sd32) begin
      n_fails++;
      $display("FAIL min_sub_all: got %0d expected 32", dp);
    end
    for (int p = 0; p < 2; p++) begin
      fill(6'b0, 6'b0);
      vec_a[p * (K - 1)] = 6'b0_00_001;
      vec_b[p * (K - 1)] = 6'b0_00_001;
      settle();
      n_checks++;
      if (dp !== 23'sd1) begin
        n_fails++;
        $display("FAIL min_sub_single[%0d]: got %0d expected 1", p * (K - 1), dp);
      end
    end
  endtask

  task automatic test_normal_scaling();
    fill(6'b0, 6'b0);
    vec_a[0] = 6'b0_01_000;
    vec_b[0] = 6'b0_11_111;
    settle();
    n_checks++;
    if (dp !== 23'sd480) begin
      n_fails++;
      $display("FAIL normal_scaling: got %0d expected 480", dp);
    end
  endtask

  task automatic test_signed_extremes();
    fill(6'b0_11_111, 6'b1_11_111);
    settle();
    n_checks++;
    if (dp !== -23'sd115200) begin
      n_fails++;
      $display("FAIL extreme_neg: got %0d expected -115200", dp);
    end
    fill(6'b1_11_111, 6'b1_11_111);
    settle();
    n_checks++;
    if (dp !== 23'sd115200) begin
      n_fails++;
      $display("FAIL extreme_pos: got %0d expected 115200", dp);
    end
  endtask

  task automatic test_zeros();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < K; j++) begin
        if ((j + r) % 2 == 0) begin
          vec_a[j] = $urandom_range(0, 1) ? 6'b100000 : 6'b000000;
          vec_b[j] = BW'($urandom_range(0, (1 << BW) - 1));
        end else begin
          vec_a[j] = BW'($urandom_range(0, (1 << BW) - 1));
          vec_b[j] = $urandom_range(0, 1) ? 6'b100000 : 6'b000000;
        end
      end
      settle();
      n_checks++;
      if (dp !== '0) begin
        n_fails++;
        $display("FAIL zeros[%0d]: got %0d expected 0", r, dp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [OW-1:0] exp_q [$];
    logic signed [OW-1:0] e;
    int shown;
    shown = 0;
    for (int c = 0; c < N_RND; c++) begin
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dp !== e) begin
          n_fails++;
          if (shown < 10) $display("FAIL stream[%0d]: got %0d expected %0d", c, dp, e);
          shown++;
        end
      end
      rand_vecs();
      exp_q.push_back(ref_dp());
      @(negedge clk);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (dp !== e) begin
        n_fails++;
        $display("FAIL stream_drain: got %0d expected %0d", dp, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    fill(6'b0_11_111, 6'b0_11_111);
    settle();
    n_checks++;
    if (dp !== 23'sd115200) begin
      n_fails++;
      $display("FAIL pre_async_reset: got %0d expected 115200", dp);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dp !== '0) begin
      n_fails++;
      $display("FAIL async_reset: got %0d expected 0", dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    n_checks++;
    if (dp !== 23'sd115200) begin
      n_fails++;
      $display("FAIL post_async_reset: got %0d expected 115200", dp);
    end
  endtask

  initial begin
    fill(6'b0, 6'b0);
    @(negedge clk);
    test_reset();
    test_min_subnormal();
    test_normal_scaling();
    test_signed_extremes();
    test_zeros();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
